// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the AXI4-lite round-robin arbiter.
//   RESP_*      : AXI response codes
//   rd_state_e  : read FSM encoding  (IDLE -> AR -> R -> IDLE)
//   wr_state_e  : write FSM encoding (IDLE -> AW_W -> B -> IDLE)
package ysyx_22050019_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AW_W = 2'd1,
    WR_B    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/ysyx_22050019_rr_sel.sv
// Combinational round-robin picker.
//   req     : per-master request vector
//   ptr     : highest-priority master index this round
//   gnt     : first requester at or after ptr, modulo NUM_M
//   any_req : at least one request present
module ysyx_22050019_rr_sel #(
  parameter int NUM_M = 2,
  parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt,
  output logic             any_req
);

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    // Walk NUM_M slots starting at ptr; the first hit wins.
    for (int i = 0; i < NUM_M; i++) begin
      if (!found && req[idx]) begin
        gnt   = idx;
        found = 1'b1;
      end
      idx = (idx == IW'(NUM_M - 1)) ? '0 : idx + IW'(1);
    end
    any_req = |req;
  end

endmodule

// File: rtl/ysyx_22050019_axi_rr_arbiter.sv
// N-master to 1-slave AXI4-lite arbiter, single-beat transfers.
// Read and write channels each run their own FSM with round-robin grant.
// Ports:
//   clk, rst          : clock, async active-high reset
//   s_ar/r/aw/w/b_*   : per-master slave-side channels (vectors / flattened buses)
//   m_ar/r/aw/w/b_*   : single master-side channels toward the memory slave
//   grant_cnt_o       : per-master completion counters, only with ARB_PERF_CNT_EN
// Optional feature macro: ARB_PERF_CNT_EN
module ysyx_22050019_axi_rr_arbiter
  import ysyx_22050019_axi_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        s_ar_valid_i,
  input  logic [NUM_M*AW-1:0]     s_ar_addr_i,
  output logic [NUM_M-1:0]        s_ar_ready_o,
  input  logic [NUM_M-1:0]        s_r_ready_i,
  output logic [NUM_M-1:0]        s_r_valid_o,
  output logic [1:0]              s_r_resp_o,
  output logic [DW-1:0]           s_r_data_o,
  input  logic [NUM_M-1:0]        s_aw_valid_i,
  input  logic [NUM_M*AW-1:0]     s_aw_addr_i,
  output logic [NUM_M-1:0]        s_aw_ready_o,
  input  logic [NUM_M-1:0]        s_w_valid_i,
  input  logic [NUM_M*DW-1:0]     s_w_data_i,
  input  logic [NUM_M*DW/8-1:0]   s_w_strb_i,
  output logic [NUM_M-1:0]        s_w_ready_o,
  input  logic [NUM_M-1:0]        s_b_ready_i,
  output logic [NUM_M-1:0]        s_b_valid_o,
  output logic [1:0]              s_b_resp_o,
  output logic                    m_ar_valid_o,
  output logic [AW-1:0]           m_ar_addr_o,
  input  logic                    m_ar_ready_i,
  input  logic                    m_r_valid_i,
  output logic                    m_r_ready_o,
  input  logic [1:0]              m_r_resp_i,
  input  logic [DW-1:0]           m_r_data_i,
  output logic                    m_aw_valid_o,
  output logic [AW-1:0]           m_aw_addr_o,
  input  logic                    m_aw_ready_i,
  output logic                    m_w_valid_o,
  output logic [DW-1:0]           m_w_data_o,
  output logic [DW/8-1:0]         m_w_strb_o,
  input  logic                    m_w_ready_i,
  input  logic                    m_b_valid_i,
  output logic                    m_b_ready_o,
  input  logic [1:0]              m_b_resp_i
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [NUM_M*CNT_W-1:0]  grant_cnt_o
`endif
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = DW / 8;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    return (g == IW'(NUM_M - 1)) ? '0 : g + IW'(1);
  endfunction

  // ---------------- read channel ----------------
  rd_state_e     rd_st;
  logic [IW-1:0] rd_g, rd_ptr, rd_pick;
  logic          rd_any, r_hs;

  ysyx_22050019_rr_sel #(.NUM_M(NUM_M), .IW(IW)) u_rd_sel (
    .req(s_ar_valid_i), .ptr(rd_ptr), .gnt(rd_pick), .any_req(rd_any)
  );

  assign r_hs = (rd_st == RD_R) && m_r_valid_i && s_r_ready_i[rd_g];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_st  <= RD_IDLE;
      rd_g   <= '0;
      rd_ptr <= '0;
    end else begin
      case (rd_st)
        RD_IDLE: if (rd_any) begin
          rd_g  <= rd_pick;
          rd_st <= RD_AR;
        end
        RD_AR: if (m_ar_ready_i) rd_st <= RD_R;
        RD_R: if (r_hs) begin
          rd_ptr <= nxt(rd_g);
          rd_st  <= RD_IDLE;
        end
        default: rd_st <= RD_IDLE;
      endcase
    end
  end

  // Only the granted master is connected; everything else reads as 0.
  always_comb begin
    m_ar_valid_o = 1'b0;
    m_ar_addr_o  = '0;
    s_ar_ready_o = '0;
    s_r_valid_o  = '0;
    s_r_resp_o   = '0;
    s_r_data_o   = '0;
    m_r_ready_o  = 1'b0;
    case (rd_st)
      RD_AR: begin
        m_ar_valid_o       = 1'b1;
        m_ar_addr_o        = s_ar_addr_i[rd_g*AW +: AW];
        s_ar_ready_o[rd_g] = m_ar_ready_i;
      end
      RD_R: begin
        s_r_valid_o[rd_g] = m_r_valid_i;
        s_r_resp_o        = m_r_resp_i;
        s_r_data_o        = m_r_data_i;
        m_r_ready_o       = s_r_ready_i[rd_g];
      end
      default: ;
    endcase
  end

  // ---------------- write channel ----------------
  wr_state_e     wr_st;
  logic [IW-1:0] wr_g, wr_ptr, wr_pick;
  logic          wr_any, aw_done, w_done, aw_hs, w_hs, b_hs;

  ysyx_22050019_rr_sel #(.NUM_M(NUM_M), .IW(IW)) u_wr_sel (
    .req(s_aw_valid_i | s_w_valid_i), .ptr(wr_ptr), .gnt(wr_pick), .any_req(wr_any)
  );

  assign aw_hs = m_aw_valid_o && m_aw_ready_i;
  assign w_hs  = m_w_valid_o && m_w_ready_i;
  assign b_hs  = (wr_st == WR_B) && m_b_valid_i && s_b_ready_i[wr_g];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_st   <= WR_IDLE;
      wr_g    <= '0;
      wr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wr_st)
        WR_IDLE: if (wr_any) begin
          wr_g  <= wr_pick;
          wr_st <= WR_AW_W;
        end
        WR_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // Either order, including both in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) wr_st <= WR_B;
        end
        WR_B: if (b_hs) begin
          wr_ptr  <= nxt(wr_g);
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          wr_st   <= WR_IDLE;
        end
        default: wr_st <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    m_aw_valid_o = 1'b0;
    m_aw_addr_o  = '0;
    s_aw_ready_o = '0;
    m_w_valid_o  = 1'b0;
    m_w_data_o   = '0;
    m_w_strb_o   = '0;
    s_w_ready_o  = '0;
    s_b_valid_o  = '0;
    s_b_resp_o   = '0;
    m_b_ready_o  = 1'b0;
    case (wr_st)
      WR_AW_W: begin
        // Each half stops forwarding once its own handshake is done.
        m_aw_valid_o       = s_aw_valid_i[wr_g] && !aw_done;
        m_aw_addr_o        = s_aw_addr_i[wr_g*AW +: AW];
        s_aw_ready_o[wr_g] = m_aw_ready_i && !aw_done;
        m_w_valid_o        = s_w_valid_i[wr_g] && !w_done;
        m_w_data_o         = s_w_data_i[wr_g*DW +: DW];
        m_w_strb_o         = s_w_strb_i[wr_g*SW +: SW];
        s_w_ready_o[wr_g]  = m_w_ready_i && !w_done;
      end
      WR_B: begin
        s_b_valid_o[wr_g] = m_b_valid_i;
        s_b_resp_o        = m_b_resp_i;
        m_b_ready_o       = s_b_ready_i[wr_g];
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic [NUM_M-1:0][CNT_W-1:0] cnt;

  for (genvar k = 0; k < NUM_M; k++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt[k] <= '0;
      else     cnt[k] <= cnt[k] + CNT_W'(r_hs && (rd_g == IW'(k)))
                                + CNT_W'(b_hs && (wr_g == IW'(k)));
    end
  end

  assign grant_cnt_o = cnt;
`endif

endmodule
